// File: rtl/mux_n_reg.sv
// Registered N-channel operand selector with valid/ready handshakes.
// Fixed-select or round-robin grant feeds a single output register slot.
module mux_n_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic [WIDTH*CHANNELS-1:0]   In,
  input  logic [CHANNELS-1:0]         InValid,
  output logic [CHANNELS-1:0]         InReady,
  input  logic [SEL_W-1:0]            S,
  input  logic                        Mode,
  output logic [WIDTH-1:0]            R,
  output logic [SEL_W-1:0]            RChan,
  output logic                        RValid,
  input  logic                        RReady
);

  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(CHANNELS);

  logic [WIDTH-1:0]    r_q, r_d;
  logic [SEL_W-1:0]    rchan_q, rchan_d;
  logic                rvalid_q, rvalid_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;

  logic                slot_free_s;
  logic [SEL_W:0]      probe_s;
  logic                rr_hit_s;
  logic                rr_found_s;
  logic [SEL_W-1:0]    rr_idx_s;
  logic [SEL_W-1:0]    cand_s;
  logic                cand_ok_s;
  logic [CHANNELS-1:0] in_ready_s;
  logic                xfer_s;
  logic [WIDTH-1:0]    cand_data_s;
  logic [SEL_W:0]      ptr_inc_s;
  logic [SEL_W-1:0]    ptr_nxt_s;

  // Round-robin search: scan from the far end so the channel closest to ptr wins.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    probe_s    = '0;
    rr_hit_s   = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      probe_s = {1'b0, ptr_q} + (SEL_W+1)'(k);
      probe_s = (probe_s >= NCH) ? (probe_s - NCH) : probe_s;
      for (int j = 0; j < CHANNELS; j++) begin
        rr_hit_s   = (probe_s == (SEL_W+1)'(j)) && InValid[j];
        rr_found_s = rr_found_s | rr_hit_s;
        rr_idx_s   = rr_hit_s ? probe_s[SEL_W-1:0] : rr_idx_s;
      end
    end
  end

  // Candidate selection, ready generation and data mux.
  always_comb begin
    slot_free_s = !rvalid_q || RReady;
    if (Mode) begin
      cand_s    = rr_idx_s;
      cand_ok_s = rr_found_s;
    end else begin
      cand_s    = S;
      cand_ok_s = ({1'b0, S} < NCH);
    end
    in_ready_s  = '0;
    cand_data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready_s[i] = cand_ok_s && slot_free_s && (cand_s == SEL_W'(i));
      cand_data_s   = (cand_s == SEL_W'(i)) ? In[i*WIDTH +: WIDTH] : cand_data_s;
    end
    xfer_s    = |(in_ready_s & InValid);
    ptr_inc_s = {1'b0, cand_s} + (SEL_W+1)'(1);
    ptr_nxt_s = (ptr_inc_s >= NCH) ? '0 : ptr_inc_s[SEL_W-1:0];
  end

  // Output slot and pointer next state.
  always_comb begin
    r_d      = r_q;
    rchan_d  = rchan_q;
    rvalid_d = rvalid_q;
    ptr_d    = ptr_q;
    if (xfer_s) begin
      r_d      = cand_data_s;
      rchan_d  = cand_s;
      rvalid_d = 1'b1;
      ptr_d    = Mode ? ptr_nxt_s : ptr_q;
    end else if (rvalid_q && RReady) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_q      <= '0;
      rchan_q  <= '0;
      rvalid_q <= 1'b0;
      ptr_q    <= '0;
    end else begin
      r_q      <= r_d;
      rchan_q  <= rchan_d;
      rvalid_q <= rvalid_d;
      ptr_q    <= ptr_d;
    end
  end

  assign InReady = in_ready_s;
  assign R       = r_q;
  assign RChan   = rchan_q;
  assign RValid  = rvalid_q;

endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench: a 4-channel and a 3-channel mux_n_reg share one random stimulus stream,
// each checked against a behavioural model of grant rules and a queue of expected words.
module tb_mux_n_reg;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst;
  logic [63:0] in_bus;
  logic [3:0]  in_valid;
  logic [1:0]  s;
  logic        mode;
  logic        rready;

  logic [3:0]  rdy_a;
  logic [2:0]  rdy_b;
  logic [15:0] r_a, r_b;
  logic [1:0]  rc_a, rc_b;
  logic        rv_a, rv_b;

  mux_n_reg #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) dut_a (
    .CLK(CLK), .Reset(rst), .In(in_bus), .InValid(in_valid), .InReady(rdy_a),
    .S(s), .Mode(mode), .R(r_a), .RChan(rc_a), .RValid(rv_a), .RReady(rready)
  );

  mux_n_reg #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) dut_b (
    .CLK(CLK), .Reset(rst), .In(in_bus[47:0]), .InValid(in_valid[2:0]), .InReady(rdy_b),
    .S(s), .Mode(mode), .R(r_b), .RChan(rc_b), .RValid(rv_b), .RReady(rready)
  );

  int n_vec = 0;
  int n_bad = 0;
  int mptr [2];
  logic [17:0] q0 [$];
  logic [17:0] q1 [$];

  function automatic int nch(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Channel granted this cycle by the selection rules, or -1 when nothing is granted.
  function automatic int grant(int d);
    if (qsize(d) != 0 && !rready) return -1;
    if (!mode) return (int'(s) < nch(d)) ? int'(s) : -1;
    for (int k = 0; k < nch(d); k++) begin
      int i;
      i = (mptr[d] + k) % nch(d);
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(string what, int d, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h", what, d, got, want);
    end
  endtask

  // Evaluate the model for the current inputs, then advance one clock.
  task automatic tick();
    bit was_rst;
    #1;
    was_rst = rst;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        int g;
        logic [3:0] want;
        logic [17:0] e;
        g = grant(d);
        want = (g >= 0) ? 4'(1 << g) : 4'b0000;
        check("in_ready", d, (d == 0) ? rdy_a : {1'b0, rdy_b}, {28'd0, want});
        check("r_valid", d, (d == 0) ? {31'd0, rv_a} : {31'd0, rv_b}, (qsize(d) != 0) ? 32'd1 : 32'd0);
        if (g >= 0 && in_valid[g]) begin
          e = {2'(g), in_bus[g*16 +: 16]};
          if (d == 0) q0.push_back(e); else q1.push_back(e);
          if (mode) mptr[d] = (g + 1) % nch(d);
        end
      end
    end else begin
      q0.delete();
      q1.delete();
      mptr = '{0, 0};
    end
    @(posedge CLK);
    #2;
    if (was_rst) begin
      check("rst_r", 0, {16'd0, r_a}, 32'd0);
      check("rst_rchan", 0, {30'd0, rc_a}, 32'd0);
      check("rst_rvalid", 0, {31'd0, rv_a}, 32'd0);
      check("rst_r", 1, {16'd0, r_b}, 32'd0);
      check("rst_rchan", 1, {30'd0, rc_b}, 32'd0);
      check("rst_rvalid", 1, {31'd0, rv_b}, 32'd0);
    end
  endtask

  task automatic pop_chk(int d);
    logic [17:0] e;
    if (qsize(d) == 0) begin
      check("unexpected_word", d, 32'd1, 32'd0);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      check("r_data", d, (d == 0) ? {16'd0, r_a} : {16'd0, r_b}, {16'd0, e[15:0]});
      check("r_chan", d, (d == 0) ? {30'd0, rc_a} : {30'd0, rc_b}, {30'd0, e[17:16]});
    end
  endtask

  // Monitor: compare each word as the consumer takes it.
  always @(negedge CLK) begin
    if (!rst) begin
      if (rv_a && rready) pop_chk(0);
      if (rv_b && rready) pop_chk(1);
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 4'hF;
    rready   = 1'b1;
    mode     = 1'b1;
    s        = 2'd0;
    in_bus   = {$urandom, $urandom};
    mptr     = '{0, 0};
    repeat (3) tick();
    rst = 1'b0;

    // Round-robin, all valid
    repeat (6) begin
      in_bus = {$urandom, $urandom};
      tick();
    end

    // Fixed sweep over every select and data -10..9
    mode = 1'b0;
    for (int sv = 0; sv < 4; sv++) begin
      for (int v = -10; v <= 9; v++) begin
        s = 2'(sv);
        in_bus = {$urandom, $urandom};
        in_bus[sv*16 +: 16] = 16'(v);
        tick();
      end
    end

    // Stall with changing source data
    s = 2'd2;
    in_bus[32 +: 16] = 16'h1234;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    in_bus[32 +: 16] = 16'h5678;
    repeat (5) tick();
    rready = 1'b1;
    repeat (2) tick();

    // Mode 1 -> 0 while stalled
    mode = 1'b1;
    tick();
    rready = 1'b0;
    tick();
    mode = 1'b0;
    tick();
    rready = 1'b1;
    tick();

    // Round-robin with only channels 1 and 3 valid
    mode = 1'b1;
    in_valid = 4'b1010;
    repeat (4) tick();

    // Out-of-range select on the 3-channel instance
    mode = 1'b0;
    in_valid = 4'hF;
    s = 2'd0;
    tick();
    s = 2'd3;
    repeat (2) tick();

    // Reset while a word is held and a transfer is pending
    mode = 1'b1;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rready = 1'b1;
    repeat (3) tick();

    // Random traffic
    repeat (1500) begin
      in_bus   = {$urandom, $urandom};
      in_valid = 4'($urandom);
      s        = 2'($urandom);
      mode     = 1'($urandom_range(0, 1));
      rready   = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 99) == 0);
      tick();
    end

    rst = 1'b0;
    rready = 1'b1;
    in_valid = 4'h0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_n_reg.md
# mux_n_reg

Parametrised, registered N-channel operand selector. It generalises the processor's 16-bit 2:1 combinational mux to `CHANNELS` inputs of `WIDTH` bits, with two selection modes:
- **Fixed**: the select input picks the channel.
- **Round-robin**: a rotating pointer picks among the valid channels.

Each input channel and the output use a valid/ready handshake. One output register stage sits between producers (register file ports, forwarding paths, I/O staging) and a single consumer.

## Interface
Parameters:
- `WIDTH`, 16, data width per channel, ≥1
- `CHANNELS`, 4, number of input channels, 2..8
- `SEL_W`, 2, select/index width; must satisfy 2^SEL_W ≥ `CHANNELS`

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  clock; all state updates on the rising edge
- `Reset`  in  1  synchronous, active-high reset
- `In`  in  `WIDTH*CHANNELS`  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- `InValid`  in  `CHANNELS`  per-channel data-valid
- `InReady`  out  `CHANNELS`  per-channel accept; at most one bit high per cycle
- `S`  in  `SEL_W`  channel select, used in fixed mode
- `Mode`  in  1  0 = fixed select, 1 = round-robin
- `R`  out  `WIDTH`  registered output data
- `RChan`  out  `SEL_W`  index of the channel whose data is held in `R`
- `RValid`  out  1  `R` holds an unconsumed word
- `RReady`  in  1  consumer accepts `R` this cycle

## Operation
- **Output slot.** A single output slot is free when `RValid`=0 or `RReady`=1. `RReady` is passed through combinationally to the ready path, so throughput is 1 word/cycle.
- **Grant (combinational).**
  - Mode 0: candidate = `S`.
  - Mode 1: candidate = the first i with `InValid[i]`=1, searching `ptr`, `ptr`+1, …, wrapping modulo `CHANNELS`.
- **Ready.** `InReady[g]`=1 only if candidate g exists, g < `CHANNELS`, and the slot is free. All other `InReady` bits are 0. `InReady` does not depend on `InValid[g]` in mode 0. In mode 1 `InReady` is asserted only toward a valid channel.
- **Transfer.** A transfer occurs when `InValid[g]` and `InReady[g]` are both high. On that edge:
  - `R` ← channel g data
  - `RChan` ← g
  - `RValid` ← 1
- **Drain.** If the slot is consumed (`RValid` && `RReady`) and no new transfer occurs, `RValid` ← 0. `R` and `RChan` keep their last value.
- **Stall.** While `RValid`=1 and `RReady`=0, `R`, `RChan` and `RValid` hold, and all `InReady` bits are 0.
- **Round-robin pointer.**
  - `ptr` (`SEL_W` bits) ← (g+1) mod `CHANNELS` after each mode-1 transfer.
  - `ptr` is unchanged on mode-0 transfers and on idle cycles.
  - `ptr` is retained across mode changes.
- **Out-of-range select.** If `S` ≥ `CHANNELS` in mode 0, there is no grant: all `InReady`=0 and no transfer. `RValid` still drains normally.
- **Mode change.** A change of `Mode` takes effect in the same cycle's grant. A word already in `R` is unaffected.
- **Data handling.** Data is passed through bit-exact with no sign or width change. Signed and unsigned data behave identically.

## Timing
- **Reset values.** `R`=0, `RChan`=0, `RValid`=0, `ptr`=0. `InReady` is combinational, so it is all 0 while `RValid`=0 and there is no candidate.
- **Reset mid-operation.** Reset overrides everything on that edge: any word held in `R` is discarded, and a concurrent transfer is not captured.
- **Latency.** A word accepted on edge n is visible on `R` with `RValid`=1 after edge n. It can be consumed in cycle n+1 at the earliest.
- **Simultaneous events.** Consume and new transfer on the same edge: the new word replaces the old one and `RValid` stays 1, with no bubble.
- **Fairness.** In mode 1 with all channels valid and `RReady` held at 1, grants cycle 0,1,…,`CHANNELS`-1,0… with one grant per cycle.
- **Combinational paths.** The only combinational paths are `S`, `Mode`, `InValid`, `RReady` → `InReady`. There is no combinational path from input to `R`.

## Test plan
Defaults (`WIDTH`=16, `CHANNELS`=4) unless stated.
- **Reset:** hold `Reset`=1 for 3 cycles with all `InValid`=1 and `RReady`=1 → `RValid`=0, `R`=0, `RChan`=0 throughout; after release, the first mode-1 grant is channel 0.
- **Fixed sweep:** mode 0; for each `S` in 0..3, drive `In` values from 16'hFFF6 (-10) to 16'h0009 (9) with all valid and `RReady`=1 → `R` equals the selected channel's value one cycle later; `RChan`=`S`; no transfers from the other channels.
- **Stall:** mode 0, `S`=2, ch2=16'h1234 accepted, then `RReady`=0 for 5 cycles while ch2 changes to 16'h5678 → `R`=16'h1234 held, `InReady`=0; after `RReady`=1, 16'h5678 appears on the next edge.
- **Round-robin:** mode 1, all valid, `RReady`=1 → `RChan` sequence 0,1,2,3,0,1; with only ch1 and ch3 valid → 1,3,1,3.
- **Boundary:** `CHANNELS`=3, `SEL_W`=2, mode 0, `S`=3 → `InReady`=0 and no transfer; a pending word drains, then `RValid`=0. In mode 1, pointer wrap from 2 goes to 0.
- **Mid-operation:** assert `Reset` while `RValid`=1 and a transfer is pending → `RValid`=0 and `ptr`=0 after the edge; switching `Mode` 1→0 while stalled leaves `R` unchanged.
